// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider / timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_div_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    typedef enum logic {
        CONT    = 1'b0,
        ONESHOT = 1'b1
    } mode_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counts 0..div_lat and pulses strobe at terminal count, optional one-shot.
// Latency: first strobe div_lat+1 edges after en is sampled high; outputs registered.
// Backpressure: none; en low returns to IDLE on the next edge (wins over terminal count).
// Ports: clk, rst (sync, active-high), en, oneshot, div[CNT_W], sync (only with
//        CLK_DIV_TIMER_SYNC_EN defined), strobe, clk_divided, busy.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] div,
`ifdef CLK_DIV_TIMER_SYNC_EN
    input  logic             sync,
`endif
    output logic             strobe,
    output logic             clk_divided,
    output logic             busy
);

    ch_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_lat;
    mode_t            mode;
    logic             sync_hit;

    assign mode = oneshot ? ONESHOT : CONT;
    assign busy = (state == RUN);

`ifdef CLK_DIV_TIMER_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_lat     <= '0;
            strobe      <= 1'b0;
            clk_divided <= 1'b0;
        end else if (!en) begin
            // Disable beats everything, including a coincident terminal count.
            state       <= IDLE;
            cnt         <= '0;
            strobe      <= 1'b0;
            clk_divided <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= RUN;
                    cnt     <= '0;
                    div_lat <= div;
                    strobe  <= 1'b0;
                end
                RUN: begin
                    if (sync_hit) begin
                        // Realign phase across channels; beats terminal count.
                        cnt         <= '0;
                        strobe      <= 1'b0;
                        clk_divided <= 1'b0;
                        div_lat     <= div;
                    end else if (cnt == div_lat) begin
                        cnt         <= '0;
                        strobe      <= 1'b1;
                        clk_divided <= ~clk_divided;
                        div_lat     <= div;
                        if (mode == ONESHOT) begin
                            state <= DONE;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        strobe <= 1'b0;
                    end
                end
                DONE: begin
                    // Park here with clk_divided frozen until en drops.
                    strobe <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_timer_mc.sv
// Multi-channel clock divider / timer: NUM_CH independent clk_div_chan instances.
// Latency: per channel, first strobe div+1 edges after en is sampled high; outputs registered.
// Backpressure: none; each channel is controlled only by its own en level.
// Ports: clk, rst (sync, active-high), en[NUM_CH], oneshot[NUM_CH], div[NUM_CH*CNT_W],
//        sync_in (only with CLK_DIV_TIMER_SYNC_EN defined), strobe/clk_divided/busy[NUM_CH].
module clk_div_timer_mc
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       oneshot,
    input  logic [NUM_CH*CNT_W-1:0] div,
`ifdef CLK_DIV_TIMER_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       strobe,
    output logic [NUM_CH-1:0]       clk_divided,
    output logic [NUM_CH-1:0]       busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .en          (en[i]),
            .oneshot     (oneshot[i]),
            .div         (div[i*CNT_W +: CNT_W]),
`ifdef CLK_DIV_TIMER_SYNC_EN
            .sync        (sync_in),
`endif
            .strobe      (strobe[i]),
            .clk_divided (clk_divided[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_clk_div_timer_mc.sv
// Self-checking bench for clk_div_timer_mc (NUM_CH=4, CNT_W=8).
// Expected per-edge outputs are queued as stimulus is applied and compared after each edge.
// Sync tests are included only when CLK_DIV_TIMER_SYNC_EN is defined.
module tb_clk_div_timer_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       oneshot;
    logic [NUM_CH*CNT_W-1:0] div;
`ifdef CLK_DIV_TIMER_SYNC_EN
    logic                    sync_in;
`endif
    logic [NUM_CH-1:0]       strobe;
    logic [NUM_CH-1:0]       clk_divided;
    logic [NUM_CH-1:0]       busy;

    always #5 clk = ~clk;

    clk_div_timer_mc #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .oneshot     (oneshot),
        .div         (div),
`ifdef CLK_DIV_TIMER_SYNC_EN
        .sync_in     (sync_in),
`endif
        .strobe      (strobe),
        .clk_divided (clk_divided),
        .busy        (busy)
    );

    typedef struct {
        string             tag;
        logic [NUM_CH-1:0] s;
        logic [NUM_CH-1:0] c;
        logic [NUM_CH-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the coming edge, advance one edge, then compare.
    task automatic step(input string tag, input logic [NUM_CH-1:0] es,
                        input logic [NUM_CH-1:0] ec, input logic [NUM_CH-1:0] eb);
        exp_t e;
        exp_q.push_back('{tag, es, ec, eb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, " strobe"},      32'(strobe),      32'(e.s));
            chk({e.tag, " clk_divided"}, 32'(clk_divided), 32'(e.c));
            chk({e.tag, " busy"},        32'(busy),        32'(e.b));
        end
    endtask

    initial begin
        logic [NUM_CH-1:0] es;
        logic [NUM_CH-1:0] ec;

        rst     = 1'b1;
        en      = '1;
        oneshot = '0;
        div     = '0;
`ifdef CLK_DIV_TIMER_SYNC_EN
        sync_in = 1'b0;
`endif
        @(negedge clk);

        // Reset holds everything idle even with en high.
        step("rst0", 4'h0, 4'h0, 4'h0);
        step("rst1", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        en  = '0;
        step("idle", 4'h0, 4'h0, 4'h0);

        // ch0 D=3, ch1 D=0, ch2 D=255 (full-range period 256), all continuous.
        div[0*CNT_W +: CNT_W] = 8'd3;
        div[1*CNT_W +: CNT_W] = 8'd0;
        div[2*CNT_W +: CNT_W] = 8'd255;
        en = 4'b0111;
        ec = '0;
        for (int k = 0; k <= 520; k++) begin
            es    = '0;
            es[0] = (k > 0) && (k % 4 == 0);
            es[1] = (k > 0);
            es[2] = (k > 0) && (k % 256 == 0);
            ec    = ec ^ es;
            step($sformatf("cont k%0d", k), es, ec, 4'b0111);
        end
        en = '0;
        step("cont off", 4'h0, 4'h0, 4'h0);

        // ch3 one-shot D=5, run twice to cover re-arm after IDLE.
        oneshot = 4'b1000;
        div[3*CNT_W +: CNT_W] = 8'd5;
        for (int r = 0; r < 2; r++) begin
            en = 4'b1000;
            for (int k = 0; k <= 15; k++) begin
                step($sformatf("os r%0d k%0d", r, k),
                     (k == 6) ? 4'b1000 : 4'b0000,
                     (k >= 6) ? 4'b1000 : 4'b0000,
                     (k < 6)  ? 4'b1000 : 4'b0000);
            end
            en = '0;
            step($sformatf("os r%0d off", r), 4'h0, 4'h0, 4'h0);
        end
        oneshot = '0;

        // ch0 D=3 changed to 1 at edge 2; then disable on a terminal count.
        div[0*CNT_W +: CNT_W] = 8'd3;
        en = 4'b0001;
        ec = '0;
        for (int k = 0; k <= 12; k++) begin
            if (k == 2) div[0*CNT_W +: CNT_W] = 8'd1;
            if (k == 12) begin
                en = '0;
                step("dchg tc-disable", 4'h0, 4'h0, 4'h0);
            end else begin
                es    = '0;
                es[0] = (k == 4) || (k == 6) || (k == 8) || (k == 10);
                ec    = ec ^ es;
                step($sformatf("dchg k%0d", k), es, ec, 4'b0001);
            end
        end

        // ch0 D=7, reset at edge 2 with en kept high; restart on the next edge.
        div[0*CNT_W +: CNT_W] = 8'd7;
        en = 4'b0001;
        ec = '0;
        for (int k = 0; k <= 14; k++) begin
            rst = (k == 2);
            if (k == 2) begin
                ec = '0;
                step("rstmid k2", 4'h0, 4'h0, 4'h0);
            end else begin
                es    = '0;
                es[0] = (k == 11);
                ec    = ec ^ es;
                step($sformatf("rstmid k%0d", k), es, ec, 4'b0001);
            end
        end
        rst = 1'b0;
        en  = '0;
        step("rstmid off", 4'h0, 4'h0, 4'h0);

`ifdef CLK_DIV_TIMER_SYNC_EN
        // ch0 D=3, ch1 D=5, sync pulse at edge 10 realigns both.
        div[0*CNT_W +: CNT_W] = 8'd3;
        div[1*CNT_W +: CNT_W] = 8'd5;
        en = 4'b0011;
        ec = '0;
        for (int k = 0; k <= 20; k++) begin
            sync_in = (k == 10);
            es    = '0;
            es[0] = (k == 4) || (k == 8) || (k == 14) || (k == 18);
            es[1] = (k == 6) || (k == 16);
            ec    = (k == 10) ? 4'b0000 : (ec ^ es);
            step($sformatf("sync k%0d", k), es, ec, 4'b0011);
        end
        sync_in = 1'b0;
        en = '0;
        step("sync off", 4'h0, 4'h0, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
